// File: rtl/textbuf_pkg.sv
// Shared types and constants for the text-cell buffer: engine states, register map, RAM port bundle.
// No logic; sizes derive from the default 40-word x 25-row screen.
package textbuf_pkg;

    localparam int DEF_ROWWORDS = 40;
    localparam int DEF_ROWS     = 25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SCR_RD,
        S_SCR_WR,
        S_SCR_FILL
    } state_t;

    localparam logic [1:0] REG_CURSORPOS   = 2'd0;
    localparam logic [1:0] REG_CURSORMODE  = 2'd1;
    localparam logic [1:0] REG_CURSORCOLOR = 2'd2;
    localparam logic [1:0] REG_CTRL        = 2'd3;

    localparam int CTRL_CLEAR  = 0;
    localparam int CTRL_SCROLL = 1;
    localparam int CTRL_BUSY   = 0;

    function automatic logic [9:0] last_word(input int rowwords, input int rows);
        return 10'(rowwords * rows - 1);
    endfunction

    function automatic logic [9:0] scroll_end(input int rowwords, input int rows);
        return 10'(rowwords * (rows - 1));
    endfunction

    localparam logic [9:0] LASTWORD  = last_word(DEF_ROWWORDS, DEF_ROWS);
    localparam logic [9:0] SCROLLEND = scroll_end(DEF_ROWWORDS, DEF_ROWS);

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } ram_port_t;

endpackage

// File: rtl/textbuf_slave_if.sv
// Wishbone classic bus between a CPU/VGA-fetch master and the text buffer responder.
// dat_m carries master write data, dat_s carries responder read data.
interface if_wb;
    logic [31:0] adr;
    logic [31:0] dat_m;
    logic [31:0] dat_s;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;

    modport master (
        output adr, dat_m, sel, we, cyc, stb,
        input  dat_s, ack
    );

    modport slave (
        input  adr, dat_m, sel, we, cyc, stb,
        output dat_s, ack
    );
endinterface

// File: rtl/textbuf_slave_textram.sv
// 1024x32 single-port synchronous RAM with per-byte write enables; contents are never reset.
// Read latency 1 cycle (old data on a same-address write).
// No backpressure: accepts one access every cycle.
module textram (
    input  logic        clk_i,
    input  logic [9:0]  addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic [31:0] rdata_o
);

    logic [31:0] mem [1024];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (be_i[k]) begin
                mem[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/textbuf_slave.sv
// Wishbone responder owning the text-cell RAM, cursor registers and a clear/scroll engine.
// Latency: ack one cycle after request, read data valid with ack.
// Backpressure: RAM requests are held (no ack) while the engine runs; register requests never stall.
module textbuf_slave
    import textbuf_pkg::*;
#(
    parameter int          ROWWORDS        = DEF_ROWWORDS,
    parameter int          ROWS            = DEF_ROWS,
    parameter logic [23:0] CURSORCOLOR_RST = 24'hFFFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_wb.slave         bus,
    output logic [31:0] cursorpos,
    output logic [3:0]  cursormode,
    output logic [23:0] cursorcolor,
    output logic        busy
);

    localparam logic [9:0] LAST_W  = last_word(ROWWORDS, ROWS);
    localparam logic [9:0] SCR_END = scroll_end(ROWWORDS, ROWS);
    localparam logic [9:0] ROW_W   = 10'(ROWWORDS);

    state_t      state_q, state_d;
    logic [9:0]  ctr_q, ctr_d;
    logic        ack_q, ack_d;
    logic        ack_ram_q;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] cpos_q, cpos_d;
    logic [3:0]  cmode_q, cmode_d;
    logic [23:0] ccol_q, ccol_d;
    logic [15:0] fill_q, fill_d;
    logic        start_clr_q, start_clr_d;
    logic        start_scr_q, start_scr_d;

    logic        req, is_reg, ram_go, reg_go;
    ram_port_t   eng, ram_req;
    logic [31:0] ram_rdata;
    logic        unused_adr;

    assign unused_adr = ^{bus.adr[31:13], bus.adr[1:0]};

    assign busy   = (state_q != S_IDLE);
    assign req    = bus.cyc & bus.stb & ~ack_q;
    assign is_reg = bus.adr[12];
    assign ram_go = req & ~is_reg & ~busy;
    assign reg_go = req & is_reg;
    assign ack_d  = ram_go | reg_go;

    textram u_ram (
        .clk_i   (clk_i),
        .addr_i  (ram_req.addr),
        .wdata_i (ram_req.wdata),
        .be_i    (ram_req.be),
        .rdata_o (ram_rdata)
    );

    // Register file: decode, byte-lane writes and registered read data.
    always_comb begin
        cpos_d      = cpos_q;
        cmode_d     = cmode_q;
        ccol_d      = ccol_q;
        fill_d      = fill_q;
        rdata_d     = rdata_q;
        start_clr_d = 1'b0;
        start_scr_d = 1'b0;
        if (reg_go) begin
            unique case (bus.adr[3:2])
                REG_CURSORPOS: begin
                    rdata_d = cpos_q;
                    if (bus.we) begin
                        for (int k = 0; k < 4; k++) begin
                            if (bus.sel[k]) cpos_d[8*k +: 8] = bus.dat_m[8*k +: 8];
                        end
                    end
                end
                REG_CURSORMODE: begin
                    rdata_d = {28'h0, cmode_q};
                    if (bus.we && bus.sel[0]) cmode_d = bus.dat_m[3:0];
                end
                REG_CURSORCOLOR: begin
                    rdata_d = {8'h0, ccol_q};
                    if (bus.we) begin
                        for (int k = 0; k < 3; k++) begin
                            if (bus.sel[k]) ccol_d[8*k +: 8] = bus.dat_m[8*k +: 8];
                        end
                    end
                end
                REG_CTRL: begin
                    rdata_d = {31'h0, busy};
                    if (bus.we && !busy) begin
                        if (bus.sel[2]) fill_d[7:0]  = bus.dat_m[23:16];
                        if (bus.sel[3]) fill_d[15:8] = bus.dat_m[31:24];
                        if (bus.sel[0]) begin
                            start_clr_d = bus.dat_m[CTRL_CLEAR];
                            start_scr_d = bus.dat_m[CTRL_SCROLL] & ~bus.dat_m[CTRL_CLEAR];
                        end
                    end
                end
                default: rdata_d = 32'h0;
            endcase
        end
    end

    // Engine: the start request is registered so busy rises the cycle after the CTRL ack.
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        eng.addr  = ctr_q;
        eng.wdata = {fill_q, fill_q};
        eng.be    = 4'h0;
        unique case (state_q)
            S_IDLE: begin
                if (start_clr_q) begin
                    state_d = S_CLR;
                    ctr_d   = 10'd0;
                end else if (start_scr_q) begin
                    state_d = S_SCR_RD;
                    ctr_d   = 10'd0;
                end
            end
            S_CLR, S_SCR_FILL: begin
                eng.be = 4'hF;
                if (ctr_q == LAST_W) begin
                    state_d = S_IDLE;
                    ctr_d   = 10'd0;
                end else begin
                    ctr_d = ctr_q + 10'd1;
                end
            end
            S_SCR_RD: begin
                eng.addr = ctr_q + ROW_W;
                state_d  = S_SCR_WR;
            end
            S_SCR_WR: begin
                eng.wdata = ram_rdata;
                eng.be    = 4'hF;
                ctr_d     = ctr_q + 10'd1;
                state_d   = (ctr_d == SCR_END) ? S_SCR_FILL : S_SCR_RD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // RAM port belongs to the engine whenever it is not idle.
    always_comb begin
        ram_req = eng;
        if (!busy) begin
            ram_req.addr  = bus.adr[11:2];
            ram_req.wdata = bus.dat_m;
            ram_req.be    = (ram_go && bus.we) ? bus.sel : 4'h0;
        end
        if (rst_i) ram_req.be = 4'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ctr_q       <= 10'd0;
            ack_q       <= 1'b0;
            ack_ram_q   <= 1'b0;
            rdata_q     <= 32'h0;
            cpos_q      <= 32'h0;
            cmode_q     <= 4'h0;
            ccol_q      <= CURSORCOLOR_RST;
            fill_q      <= 16'h0;
            start_clr_q <= 1'b0;
            start_scr_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            ack_q       <= ack_d;
            ack_ram_q   <= ram_go;
            rdata_q     <= rdata_d;
            cpos_q      <= cpos_d;
            cmode_q     <= cmode_d;
            ccol_q      <= ccol_d;
            fill_q      <= fill_d;
            start_clr_q <= start_clr_d;
            start_scr_q <= start_scr_d;
        end
    end

    assign bus.ack     = ack_q;
    assign bus.dat_s   = ack_ram_q ? ram_rdata : rdata_q;
    assign cursorpos   = cpos_q;
    assign cursormode  = cmode_q;
    assign cursorcolor = ccol_q;

endmodule

// File: tb/tb_textbuf_slave.sv
// Randomized bench for textbuf_slave against a word-array model of the screen and registers.
module tb_textbuf_slave;
    import textbuf_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cursorpos;
    logic [3:0]  cursormode;
    logic [23:0] cursorcolor;
    logic        busy;

    always #5 clk = ~clk;

    if_wb bus();

    textbuf_slave #(
        .ROWWORDS        (40),
        .ROWS            (25),
        .CURSORCOLOR_RST (24'hFFFFFF)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .cursorpos   (cursorpos),
        .cursormode  (cursormode),
        .cursorcolor (cursorcolor),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    logic [31:0] mem_m [1024];
    bit          known_m [1024];
    logic [31:0] pos_m;
    logic [3:0]  mode_m;
    logic [23:0] col_m;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] r, output int lat);
        bus.adr = a; bus.we = w; bus.dat_m = d; bus.sel = s; bus.cyc = 1'b1; bus.stb = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus.ack && lat < 4000);
        r = bus.dat_s;
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] r;
        logic [31:0] exp_r [4];
        int lat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        pos_m = 32'h0; mode_m = 4'h0; col_m = 24'hFFFFFF;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cursorpos !== 32'h0) begin errors++; $display("FAIL reset_pos: got %h want 0", cursorpos); end
        checks++; if (cursormode !== 4'h0) begin errors++; $display("FAIL reset_mode: got %h want 0", cursormode); end
        checks++; if (cursorcolor !== 24'hFFFFFF) begin errors++; $display("FAIL reset_color: got %h want FFFFFF", cursorcolor); end
        checks++; if (bus.ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.ack); end
        checks++; if (bus.dat_s !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h want 0", bus.dat_s); end
        exp_r[0] = 32'h0; exp_r[1] = 32'h0; exp_r[2] = 32'h00FFFFFF; exp_r[3] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            xfer(32'h1000 + 32'(4 * i), 1'b0, 32'h0, 4'hF, r, lat);
            checks++; if (r !== exp_r[i]) begin errors++; $display("FAIL reset_reg%0d: got %h want %h", i, r, exp_r[i]); end
            checks++; if (lat !== 1) begin errors++; $display("FAIL reset_reg%0d_lat: got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_ram_rw();
        logic [31:0] r, d;
        logic [3:0]  s;
        int lat, w;
        int words [$];
        xfer(32'd20, 1'b1, 32'h1F411F42, 4'hF, r, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
        xfer(32'd20, 1'b1, 32'h00000043, 4'h1, r, lat);
        xfer(32'd20, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h1F411F43) begin errors++; $display("FAIL ram_lane: got %h want 1F411F43", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ram_rd_lat: got %0d want 1", lat); end
        mem_m[5] = 32'h1F411F43; known_m[5] = 1'b1;
        for (int i = 0; i < 24; i++) begin
            w = $urandom_range(0, 1023);
            d = $urandom;
            s = known_m[w] ? 4'($urandom_range(1, 15)) : 4'hF;
            xfer(32'(w * 4), 1'b1, d, s, r, lat);
            mem_m[w] = known_m[w] ? merge(mem_m[w], d, s) : d;
            known_m[w] = 1'b1;
            words.push_back(w);
        end
        foreach (words[i]) begin
            xfer(32'(words[i] * 4), 1'b0, 32'h0, 4'hF, r, lat);
            checks++; if (r !== mem_m[words[i]]) begin errors++; $display("FAIL ram_rand w%0d: got %h want %h", words[i], r, mem_m[words[i]]); end
        end
    endtask

    task automatic test_regs();
        logic [31:0] r, d, want;
        logic [3:0]  s;
        int lat, idx;
        for (int i = 0; i < 12; i++) begin
            idx = $urandom_range(0, 2);
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            case (idx)
                0: pos_m = merge(pos_m, d, s);
                1: if (s[0]) mode_m = d[3:0];
                default: for (int k = 0; k < 3; k++) if (s[k]) col_m[8*k +: 8] = d[8*k +: 8];
            endcase
            xfer(32'h1000 + 32'(idx * 4), 1'b1, d, s, r, lat);
            checks++; if (lat !== 1) begin errors++; $display("FAIL reg_wr_lat: got %0d want 1", lat); end
            checks++; if ({cursorpos, cursormode, cursorcolor} !== {pos_m, mode_m, col_m})
                begin errors++; $display("FAIL reg_ports: got %h/%h/%h want %h/%h/%h", cursorpos, cursormode, cursorcolor, pos_m, mode_m, col_m); end
            want = (idx == 0) ? pos_m : (idx == 1) ? {28'h0, mode_m} : {8'h0, col_m};
            xfer(32'h1000 + 32'(idx * 4), 1'b0, 32'h0, 4'hF, r, lat);
            checks++; if (r !== want) begin errors++; $display("FAIL reg_rd%0d: got %h want %h", idx, r, want); end
        end
    endtask

    task automatic test_clear();
        logic [31:0] r;
        logic [15:0] f;
        int lat, n, k, w;
        int probe [4];
        xfer(32'd4040, 1'b1, 32'hA5A50F0F, 4'hF, r, lat);
        mem_m[1010] = 32'hA5A50F0F; known_m[1010] = 1'b1;
        f = 16'h0720;
        xfer(32'h100C, 1'b1, {f, 16'h0001}, 4'hF, r, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL clr_ctrl_lat: got %0d want 1", lat); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", busy); end
        wait_idle(n);
        checks++; if (n !== 1000) begin errors++; $display("FAIL clr_busy_len: got %0d want 1000", n); end
        for (int i = 0; i <= int'(LASTWORD); i++) begin mem_m[i] = {f, f}; known_m[i] = 1'b1; end
        probe[0] = 0; probe[1] = 500; probe[2] = 999; probe[3] = 1010;
        foreach (probe[i]) begin
            xfer(32'(probe[i] * 4), 1'b0, 32'h0, 4'hF, r, lat);
            checks++; if (r !== mem_m[probe[i]]) begin errors++; $display("FAIL clr_word%0d: got %h want %h", probe[i], r, mem_m[probe[i]]); end
        end
        // both bits set: clear wins; a RAM read issued mid-clear waits for busy to fall
        f = 16'($urandom);
        xfer(32'h100C, 1'b1, {f, 16'h0003}, 4'hF, r, lat);
        k = $urandom_range(1, 900);
        repeat (k - 1) @(posedge clk);
        #0;
        w = $urandom_range(0, 999);
        xfer(32'(w * 4), 1'b0, 32'h0, 4'hF, r, lat);
        for (int i = 0; i <= int'(LASTWORD); i++) mem_m[i] = {f, f};
        checks++; if (lat !== 1002 - k) begin errors++; $display("FAIL clr_stall_lat: got %0d want %0d", lat, 1002 - k); end
        checks++; if (r !== {f, f}) begin errors++; $display("FAIL clr_stall_data: got %h want %h", r, {f, f}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_stall_busy: got %b want 0", busy); end
    endtask

    task automatic test_scroll();
        logic [31:0] r, d;
        logic [31:0] nxt [1024];
        logic [15:0] f;
        int lat, n;
        for (int i = 0; i < 1024; i++) begin
            d = $urandom;
            xfer(32'(i * 4), 1'b1, d, 4'hF, r, lat);
            mem_m[i] = d; known_m[i] = 1'b1;
        end
        f = 16'($urandom);
        xfer(32'h100C, 1'b1, {f, 16'h0002}, 4'hF, r, lat);
        wait_idle(n);
        checks++; if (n !== 1960) begin errors++; $display("FAIL scr_busy_len: got %0d want 1960", n); end
        for (int i = 0; i < 1024; i++) begin
            if (i < int'(SCROLLEND)) nxt[i] = mem_m[i + DEF_ROWWORDS];
            else if (i <= int'(LASTWORD)) nxt[i] = {f, f};
            else nxt[i] = mem_m[i];
        end
        for (int i = 0; i < 1024; i++) mem_m[i] = nxt[i];
        for (int i = 0; i < 1024; i++) begin
            xfer(32'(i * 4), 1'b0, 32'h0, 4'hF, r, lat);
            checks++; if (r !== mem_m[i]) begin errors++; $display("FAIL scr_word%0d: got %h want %h", i, r, mem_m[i]); end
        end
    endtask

    task automatic test_busy_access();
        logic [31:0] r;
        logic [15:0] f;
        logic [3:0]  m;
        int lat, n, start;
        bit acked;
        f = 16'($urandom);
        xfer(32'h100C, 1'b1, {f, 16'h0001}, 4'hF, r, lat);
        start = cyc_cnt;
        // RAM write held off by the engine, then abandoned by dropping cyc
        bus.adr = 32'd2800; bus.we = 1'b1; bus.dat_m = 32'hDEADBEEF; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        acked = 1'b0;
        repeat (5) begin @(posedge clk); #1; if (bus.ack) acked = 1'b1; end
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        @(posedge clk); #1;
        checks++; if (acked !== 1'b0) begin errors++; $display("FAIL busy_stall_ack: got %b want 0", acked); end
        xfer(32'h100C, 1'b1, {~f, 16'h0002}, 4'hF, r, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL busy_ctrl_lat: got %0d want 1", lat); end
        m = 4'($urandom_range(1, 2));
        mode_m = m;
        xfer(32'h1004, 1'b1, {28'h0, m}, 4'hF, r, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL busy_mode_lat: got %0d want 1", lat); end
        checks++; if (cursormode !== mode_m) begin errors++; $display("FAIL busy_mode: got %h want %h", cursormode, mode_m); end
        xfer(32'h100C, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h1) begin errors++; $display("FAIL busy_ctrl_rd: got %h want 1", r); end
        wait_idle(n);
        checks++; if (cyc_cnt - start !== 1000) begin errors++; $display("FAIL busy_len: got %0d want 1000", cyc_cnt - start); end
        for (int i = 0; i <= int'(LASTWORD); i++) mem_m[i] = {f, f};
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignored_ctrl: got %b want 0", busy); end
        xfer(32'd0, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== {f, f}) begin errors++; $display("FAIL busy_word0: got %h want %h", r, {f, f}); end
        xfer(32'd2800, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== {f, f}) begin errors++; $display("FAIL busy_word700: got %h want %h", r, {f, f}); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        logic [15:0] f;
        int lat;
        col_m = 24'($urandom) & 24'h7FFFFF;
        xfer(32'h1008, 1'b1, {8'h0, col_m}, 4'hF, r, lat);
        checks++; if (cursorcolor !== col_m) begin errors++; $display("FAIL rmid_color_set: got %h want %h", cursorcolor, col_m); end
        xfer(32'd1600, 1'b1, 32'h12345678, 4'hF, r, lat);
        mem_m[400] = 32'h12345678;
        f = 16'($urandom) ^ 16'h5555;
        if (f == mem_m[600][15:0]) f = ~f;
        xfer(32'h100C, 1'b1, {f, 16'h0001}, 4'hF, r, lat);
        repeat (299) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (cursorcolor !== 24'hFFFFFF) begin errors++; $display("FAIL rmid_color: got %h want FFFFFF", cursorcolor); end
        rst = 1'b0;
        pos_m = 32'h0; mode_m = 4'h0; col_m = 24'hFFFFFF;
        for (int i = 0; i < 299; i++) mem_m[i] = {f, f};
        known_m[299] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        xfer(32'd0, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== mem_m[0]) begin errors++; $display("FAIL rmid_word0: got %h want %h", r, mem_m[0]); end
        xfer(32'd1192, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== mem_m[298]) begin errors++; $display("FAIL rmid_word298: got %h want %h", r, mem_m[298]); end
        xfer(32'd1600, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL rmid_word400: got %h want 12345678", r); end
        xfer(32'd2400, 1'b0, 32'h0, 4'hF, r, lat);
        checks++; if (r !== mem_m[600]) begin errors++; $display("FAIL rmid_word600: got %h want %h", r, mem_m[600]); end
    endtask

    initial begin
        bus.adr = 32'h0; bus.dat_m = 32'h0; bus.sel = 4'h0;
        bus.we = 1'b0; bus.cyc = 1'b0; bus.stb = 1'b0;
        rst = 1'b1;
        test_reset();
        test_ram_rw();
        test_regs();
        test_clear();
        test_scroll();
        test_busy_access();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/textbuf_slave.md
Name: textbuf_slave

Overview:
- Wishbone classic responder that owns the 80x25 text-cell RAM and the cursor/control registers consumed by the VGA text driver.
- Serves the driver's read fetches (one 32-bit word = two cells: {attr0, char0, attr1, char1}) and CPU reads/writes on the same bus.
- Contains a hardware clear/scroll engine so software does not have to rewrite 1000 words itself.

Parameters:
- ROWWORDS, 40, words per text row (160 bytes).
- ROWS, 25, text rows.
- CURSORCOLOR_RST, 24'hFFFFFF, reset value of cursorcolor.

Ports:
- clk_i  input  1  system clock; all logic is on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- cursorpos  output  32  {row[15:0], col[15:0]} cursor cell position.
- cursormode  output  4  0 = off, 1 = blink, 2 = solid.
- cursorcolor  output  24  cursor RGB.
- busy  output  1  clear/scroll engine active.
- bus  if_wb.slave  -  Wishbone slave (adr, dat_i/dat_o, sel, we, cyc, stb, ack). Under NO_MODPORT_EXPRESSIONS use dat_m/dat_s.

Behaviour:
- Reset: ack=0, dat_o=0, cursorpos=0, cursormode=0, cursorcolor=CURSORCOLOR_RST, busy=0, engine S_IDLE, counter=0. RAM contents are not reset.
- Decode on byte address adr[12]:
  - adr[12]=0: RAM word adr[11:2], 1024 words; words 0..999 are visible.
  - adr[12]=1: registers at adr[3:2]: 0 CURSORPOS, 1 CURSORMODE, 2 CURSORCOLOR, 3 CTRL.
- Handshake:
  - Request = cyc&stb&!ack.
  - ack is a one-cycle pulse one cycle after the request, so each access takes 2 cycles; back-to-back requests are acked every other cycle.
  - Read data is valid in the ack cycle.
  - Writes honour sel byte lanes for RAM and registers.
- Unused register bits read 0. CTRL read returns {16'h0, 15'h0, busy}.
- CTRL write:
  - Fill halfword = dat[31:16].
  - bit0 = clear. bit1 = scroll. If both are set, clear wins.
  - Writes while busy=1 are acked and ignored.
- Engine states: S_IDLE, S_CLR, S_SCR_RD, S_SCR_WR, S_SCR_FILL.
  - S_CLR: writes {fill, fill} to word ctr, ctr 0..999, one word per cycle. After word 999, go to S_IDLE; total 1000 cycles.
  - S_SCR_RD: read word ctr+ROWWORDS.
  - S_SCR_WR: write that data to word ctr; ctr++. When ctr reaches 960, go to S_SCR_FILL; otherwise return to S_SCR_RD. This costs 2 cycles per word.
  - S_SCR_FILL: writes {fill, fill} to words 960..999, one per cycle, then S_IDLE.
  - busy=1 from the cycle after the CTRL ack through the last engine write. It is 0 in the cycle after that.
- Bus arbitration while busy:
  - RAM requests are stalled (ack withheld) until busy falls. The request is then served with normal 1-cycle latency.
  - Register requests are acked normally.
  - RAM requests to words 1000..1023 behave as ordinary storage.
- Reset mid-operation returns the engine to S_IDLE immediately. A partially cleared or scrolled RAM is acceptable, and no further engine writes occur.
- Simultaneous events: the engine owns the RAM port whenever state != S_IDLE. A bus RAM write in the same cycle busy rises must not occur; the request is stalled.
- cyc dropping during a stall abandons the request, with no side effects.

Decomposition:
- Package textbuf_pkg: engine state_t enum, register offsets (REG_CURSORPOS..REG_CTRL), ROWWORDS/ROWS-derived constants LASTWORD=999 and SCROLLEND=960, CTRL bit positions.
- One sub-module, textram: 1024x32 single-port synchronous RAM with 4-bit byte write enable and 1-cycle read latency. Address/data/we are muxed between bus and engine in textbuf_slave.

Test Plan:
- Reset, then read 0x1000/0x1004/0x1008/0x100C -> 0, 0, 32'h00FFFFFF, 0; each ack exactly 1 cycle after stb.
- Write word 5 = 32'h1F411F42 with sel=4'hF, then write sel=4'h1 data 32'h00000043 -> reading word 5 returns 32'h1F411F43.
- CTRL write 32'h07200001 -> busy high for 1000 cycles; words 0, 500 and 999 read 32'h07200720. A RAM read issued mid-clear acks only after busy drops.
- Fill row r (words 40r..40r+39) with value r, then CTRL 32'h07200002 -> word 0 = 1, word 919 = 23, words 960..999 = 32'h07200720. Busy lasts 1920+40 cycles.
- Assert rst_i at cycle 300 of a clear -> busy=0 next cycle; word 400 keeps its pre-clear value; cursorcolor returns to FFFFFF.
- CTRL write while busy, and cursormode write while busy -> CTRL ignored (busy timing unchanged); cursormode updates and is acked in 1 cycle.
